// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: multi-cycle FETCH/INC/EXEC sequencer that drives PC load enable and ALU operand selects.
// Interrupt entry (irq/irq_ack ports, IRQ state) is compiled in only when PC_SEQ_IRQ_EN is defined.
module pc_seq_ctrl #(
    parameter logic [15:0] IRQ_VECTOR = 16'h0004,
    parameter logic [3:0]  OPC_BRANCH = 4'hC,
    parameter logic [3:0]  OPC_HALT   = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
`ifdef PC_SEQ_IRQ_EN
    input  logic        irq,
    output logic        irq_ack,
`endif
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic [15:0] ir,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [15:0] imm,
    output logic        pc_en,
    output logic        rf_we,
    output logic        halted,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_INC   = 3'd2,
        S_EXEC  = 3'd3,
        S_IRQ   = 3'd4,
        S_HALT  = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        irq_pend;
    logic [3:0]  opc;

`ifdef PC_SEQ_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
    assign irq_pend = irq;
    assign irq_ack  = (state_q == S_IRQ);
`else
    localparam bit IRQ_EN = 1'b0;
    assign irq_pend = 1'b0;
`endif

    assign opc   = ir_q[15:12];
    assign ir    = ir_q;
    assign state = state_q;
    assign imm   = (IRQ_EN && state_q == S_IRQ) ? IRQ_VECTOR : {{8{ir_q[7]}}, ir_q[7:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // irq is only looked at when leaving IDLE or EXEC, so an instruction is never split.
    always_comb begin
        state_d   = S_IDLE;
        ir_d      = ir_q;
        mem_req   = 1'b0;
        alu_a_sel = 2'd0;
        alu_b_sel = 2'd0;
        pc_en     = 1'b0;
        rf_we     = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_IDLE:  state_d = irq_pend ? S_IRQ : S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                ir_d    = mem_ack ? mem_rdata : ir_q;
                state_d = mem_ack ? S_INC : S_FETCH;
            end
            S_INC: begin
                alu_a_sel = 2'd1;
                alu_b_sel = 2'd1;
                pc_en     = 1'b1;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                if (opc == OPC_BRANCH) begin
                    alu_a_sel = 2'd1;
                    alu_b_sel = 2'd2;
                    pc_en     = branch_taken;
                end else if (opc != OPC_HALT) begin
                    rf_we = 1'b1;
                end
                state_d = (opc == OPC_HALT) ? S_HALT : irq_pend ? S_IRQ : S_FETCH;
            end
            S_IRQ: begin
                if (IRQ_EN) begin
                    alu_a_sel = 2'd2;
                    alu_b_sel = 2'd2;
                    pc_en     = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
